// File: rtl/dac_write_arbiter.sv
// Purpose: round-robin arbiter sharing one AD5791 DAC channel between four requesters (servo, sweep, PC, cal).
// Latency: 1 cycle from request to DAC_out/update_out in IDLE; ack_out UPDATE_PERIOD cycles after the update.
// Backpressure: requests are levels held until ack_out; at most one grant in flight, others wait in round-robin order.
// Optional feature: define DAC_ARB_CLAMP_EN to saturate latched codes to [CLAMP_MIN, CLAMP_MAX].
module dac_write_arbiter #(
    parameter int                 UPDATE_PERIOD = 128,
    parameter logic signed [19:0] CLAMP_MIN     = -20'sd524288,
    parameter logic signed [19:0] CLAMP_MAX     = 20'sd524287
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  req_in,
    input  logic [79:0] data_in,
    output logic [3:0]  ack_out,
    output logic [1:0]  grant_out,
    output logic        busy_out,
    output logic        update_out,
    output logic [19:0] DAC_out,
    output logic        clamp_flag_out
);

    localparam int           CW   = $clog2(UPDATE_PERIOD);
    localparam logic [CW-1:0] LOAD = CW'(UPDATE_PERIOD - 1);

    // Reject configurations that cannot guarantee a full SPI frame or a valid clamp window.
    generate
        if (UPDATE_PERIOD < 2) begin : g_bad_period
            $error("dac_write_arbiter: UPDATE_PERIOD must be at least 2");
        end
        if (CLAMP_MIN > CLAMP_MAX) begin : g_bad_clamp
            $error("dac_write_arbiter: CLAMP_MIN must not exceed CLAMP_MAX");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_last;
    logic [1:0]         r_grant;
    logic [3:0]         r_ack;
    logic               r_busy;
    logic               r_upd;
    logic               r_clamp;
    logic [19:0]        r_dac;

    logic [3:0]         w_eff_req;
    logic               w_sel_vld;
    logic [1:0]         w_sel_idx;
    logic signed [19:0] w_sel_code;
    logic signed [19:0] w_code;
    logic               w_clip;

    // First set request bit searching last+1, last+2, ... modulo 4; returns {valid, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] idx;
        logic [1:0] pick;
        found = 1'b0;
        pick  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    // Round-robin choice among requesters, ignoring the one being acknowledged this cycle.
    always_comb begin
        w_eff_req              = req_in & ~r_ack;
        {w_sel_vld, w_sel_idx} = rr_pick(w_eff_req, r_last);
        case (w_sel_idx)
            2'd0:    w_sel_code = data_in[19:0];
            2'd1:    w_sel_code = data_in[39:20];
            2'd2:    w_sel_code = data_in[59:40];
            default: w_sel_code = data_in[79:60];
        endcase
    end

`ifdef DAC_ARB_CLAMP_EN
    // Signed saturation of the selected code; w_clip marks that the value was altered.
    always_comb begin
        w_code = w_sel_code;
        w_clip = 1'b0;
        if (w_sel_code > CLAMP_MAX) begin
            w_code = CLAMP_MAX;
            w_clip = 1'b1;
        end else if (w_sel_code < CLAMP_MIN) begin
            w_code = CLAMP_MIN;
            w_clip = 1'b1;
        end
    end
`else
    assign w_code = w_sel_code;
    assign w_clip = 1'b0;
`endif

    // Grant/dwell FSM: latch the code at grant, hold it for UPDATE_PERIOD cycles, then acknowledge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_grant <= 2'd0;
            r_ack   <= 4'd0;
            r_busy  <= 1'b0;
            r_upd   <= 1'b0;
            r_clamp <= 1'b0;
            r_dac   <= 20'd0;
        end else begin
            r_upd   <= 1'b0;
            r_ack   <= 4'd0;
            r_clamp <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_vld) begin
                        r_dac   <= w_code;
                        r_grant <= w_sel_idx;
                        r_last  <= w_sel_idx;
                        r_upd   <= 1'b1;
                        r_clamp <= w_clip;
                        r_busy  <= 1'b1;
                        r_cnt   <= LOAD;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_ack   <= 4'b0001 << r_grant;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ack_out        = r_ack;
    assign grant_out      = r_grant;
    assign busy_out       = r_busy;
    assign update_out     = r_upd;
    assign DAC_out        = r_dac;
    assign clamp_flag_out = r_clamp;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter: directed scenarios plus randomized traffic against a cycle-level reference.
// The reference predicts each output from the arbitration rules (rotating priority, fixed dwell, masked ack).
// Build with or without DAC_ARB_CLAMP_EN; expectations follow the macro.
module tb_dac_write_arbiter;

    localparam int P = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in;
    logic [79:0] data_in;
    logic [3:0]  ack_out;
    logic [1:0]  grant_out;
    logic        busy_out;
    logic        update_out;
    logic [19:0] DAC_out;
    logic        clamp_flag_out;

    always #5 clk_in = ~clk_in;

    dac_write_arbiter #(
        .UPDATE_PERIOD(P),
        .CLAMP_MIN(-20'sd1000),
        .CLAMP_MAX(20'sd1000)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_in(req_in),
        .data_in(data_in),
        .ack_out(ack_out),
        .grant_out(grant_out),
        .busy_out(busy_out),
        .update_out(update_out),
        .DAC_out(DAC_out),
        .clamp_flag_out(clamp_flag_out)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state
    logic [19:0] m_dac;
    logic [1:0]  m_grant;
    logic        m_busy;
    logic        m_upd;
    logic        m_clamp;
    logic [3:0]  m_ack;
    int          m_last;
    bit          m_hold;
    int          m_ack_at;
    int          cyc_n = 0;
    bit          cmp_en = 1'b0;
    int          upd_cyc[$];
    int          upd_grant[$];

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [3:0]         prev_ack;
        logic [3:0]         eff;
        logic signed [19:0] s;
        int                 v;
        int                 c;
        int                 k;
        bit                 picked;
        prev_ack = m_ack;
        if (rst_in === 1'b1) begin
            m_dac = '0; m_grant = '0; m_busy = 0; m_upd = 0; m_clamp = 0; m_ack = '0;
            m_last = 3; m_hold = 0; m_ack_at = 0;
            return;
        end
        m_upd = 0; m_ack = '0; m_clamp = 0;
        if (m_hold) begin
            if (cyc_n == m_ack_at) begin
                m_ack[m_grant] = 1'b1;
                m_busy = 0;
                m_hold = 0;
            end
        end else begin
            eff    = req_in & ~prev_ack;
            picked = 0;
            for (int i = 1; i <= 4; i++) begin
                k = (m_last + i) % 4;
                if (!picked && eff[k]) begin
                    picked = 1;
                    s = data_in[k*20 +: 20];
                    v = s;
                    c = v;
`ifdef DAC_ARB_CLAMP_EN
                    if (v > 1000) c = 1000;
                    else if (v < -1000) c = -1000;
`endif
                    m_dac    = c[19:0];
                    m_clamp  = (c != v);
                    m_grant  = 2'(k);
                    m_last   = k;
                    m_upd    = 1;
                    m_busy   = 1;
                    m_hold   = 1;
                    m_ack_at = cyc_n + P;
                end
            end
        end
    endtask

    // Single compare process: reference advanced at each edge, DUT checked 1 time unit later.
    always @(posedge clk_in) begin
        cyc_n++;
        model_step();
        #1;
        if (cmp_en) begin
            check("cyc_dac",   32'(DAC_out),        32'(m_dac));
            check("cyc_grant", 32'(grant_out),      32'(m_grant));
            check("cyc_busy",  32'(busy_out),       32'(m_busy));
            check("cyc_upd",   32'(update_out),     32'(m_upd));
            check("cyc_ack",   32'(ack_out),        32'(m_ack));
            check("cyc_clamp", 32'(clamp_flag_out), 32'(m_clamp));
            if (update_out === 1'b1) begin
                upd_cyc.push_back(cyc_n);
                upd_grant.push_back(int'(grant_out));
            end
        end
    end

    // Apply inputs at a falling edge and return at the next falling edge.
    task automatic step(input logic r, input logic [3:0] q, input logic [79:0] d);
        rst_in  = r;
        req_in  = q;
        data_in = d;
        @(negedge clk_in);
    endtask

    initial begin
        logic [79:0] d;
        logic [79:0] d2;
        logic [3:0]  q;
        logic [19:0] e;
        logic [19:0] code;
        int          exp_g[5];

        rst_in  = 1'b1;
        req_in  = '0;
        data_in = '0;
        @(negedge clk_in);
        cmp_en = 1'b1;

        // Reset then idle
        step(1, 0, '0);
        check("rst_dac",  32'(DAC_out),  0);
        check("rst_busy", 32'(busy_out), 0);
        repeat (20) step(0, 0, '0);
        check("idle_dac",   32'(DAC_out),    0);
        check("idle_upd",   32'(update_out), 0);
        check("idle_grant", 32'(grant_out),  0);

        // Single request, held through the ack cycle
        d = '0;
        d[19:0] = 20'h12345;
        step(0, 4'b0001, d);
        check("single_upd",   32'(update_out), 1);
        check("single_dac",   32'(DAC_out),    32'h12345);
        check("single_busy",  32'(busy_out),   1);
        for (int i = 0; i < P - 1; i++) begin
            step(0, 4'b0001, d);
            check("single_noack", 32'(ack_out), 0);
        end
        step(0, 4'b0001, d);
        check("single_ack", 32'(ack_out), 32'b0001);
        step(0, 4'b0001, d);
        check("single_noregrant_upd",  32'(update_out), 0);
        check("single_noregrant_busy", 32'(busy_out),   0);
        step(0, 4'b0000, d);

        // Contention: all four requesters held
        step(1, 0, '0);
        upd_cyc.delete();
        upd_grant.delete();
        d = {20'h40004, 20'h30003, 20'h20002, 20'h10001};
        repeat (40) step(0, 4'b1111, d);
        exp_g = '{0, 1, 2, 3, 0};
        check("rr_count_ge5", 32'(upd_cyc.size() >= 5), 1);
        if (upd_cyc.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr_order", 32'(upd_grant[i]), 32'(exp_g[i]));
            for (int i = 1; i < 5; i++) check("rr_spacing", 32'(upd_cyc[i] - upd_cyc[i-1]), 9);
        end

        // Request drop mid-dwell, then reset mid-dwell
        step(1, 0, '0);
        d = '0;
        d[59:40] = 20'h0ABCD;
        step(0, 4'b0100, d);
        check("drop_grant", 32'(grant_out), 2);
        step(0, 4'b0100, d);
        step(0, 4'b0100, d);
        d2 = d;
        d2[59:40] = 20'h55555;
        for (int i = 0; i < P - 3; i++) step(0, 4'b0000, d2);
        check("drop_noack_early", 32'(ack_out), 0);
        step(0, 4'b0000, d2);
        check("drop_ack", 32'(ack_out), 32'b0100);
        check("drop_dac", 32'(DAC_out), 32'h0ABCD);
        step(0, 0, '0);
        step(0, 4'b0100, d);
        repeat (4) step(0, 4'b0100, d);
        step(1, 4'b0100, d);
        check("rst_mid_dac",  32'(DAC_out),  0);
        check("rst_mid_ack",  32'(ack_out),  0);
        check("rst_mid_busy", 32'(busy_out), 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 4'b0000, '0);
            check("rst_mid_noack", 32'(ack_out), 0);
        end

        // Saturation behaviour
        step(1, 0, '0);
        d = '0;
        code = 20'd5000;
        d[19:0] = code;
        step(0, 4'b0001, d);
`ifdef DAC_ARB_CLAMP_EN
        check("sat_hi_dac",  32'(DAC_out),        32'd1000);
        check("sat_hi_flag", 32'(clamp_flag_out), 1);
`else
        check("sat_hi_dac",  32'(DAC_out),        32'd5000);
        check("sat_hi_flag", 32'(clamp_flag_out), 0);
`endif
        repeat (P) step(0, 4'b0001, d);
        step(0, 4'b0000, d);
        d = '0;
        code = -20'sd5000;
        d[39:20] = code;
        step(0, 4'b0010, d);
`ifdef DAC_ARB_CLAMP_EN
        e = -20'sd1000;
        check("sat_lo_flag", 32'(clamp_flag_out), 1);
`else
        e = -20'sd5000;
        check("sat_lo_flag", 32'(clamp_flag_out), 0);
`endif
        check("sat_lo_dac", 32'(DAC_out), 32'(e));
        repeat (P) step(0, 4'b0010, d);
        step(0, 4'b0000, d);

        // Randomized traffic with level requests released on ack
        step(1, 0, '0);
        q = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (ack_out[k]) q[k] = 1'b0;
                else if (!q[k] && $urandom_range(3) == 0) q[k] = 1'b1;
                else if (q[k] && $urandom_range(60) == 0) q[k] = 1'b0;
                if ($urandom_range(1) == 0) code = 20'($urandom);
                else code = 20'($urandom_range(2400)) - 20'd1200;
                d[k*20 +: 20] = code;
            end
            if ($urandom_range(299) == 0) begin
                step(1, q, d);
                q = '0;
            end else begin
                step(0, q, d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_write_arbiter.md
# dac_write_arbiter

Round-robin arbiter that shares one AD5791 DAC channel between four requesters: servo loop, sweep/ramp generator, PC override and calibration. It grants one requester at a time and latches that requester's 20-bit code onto the DAC word bus feeding the AD5791 controller. It then holds the code for a fixed dwell of at least one full SPI frame before acknowledging, so every granted code is guaranteed to reach the DAC register.

## Interface
Parameters:
- UPDATE_PERIOD, 128: dwell in clk_in cycles per granted code; must be ≥ 2 and ≥ one AD5791 SPI frame plus overhead.
- CLAMP_MIN, -20'sd524288: lower saturation bound (signed 20-bit); used only with DAC_ARB_CLAMP_EN.
- CLAMP_MAX, 20'sd524287: upper saturation bound (signed 20-bit); used only with DAC_ARB_CLAMP_EN. Requires CLAMP_MIN ≤ CLAMP_MAX.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- req_in  input  4  per-requester write request; level, held until the matching ack.
- data_in  input  80  four signed 20-bit codes, requester k at bits [20k+19:20k].
- ack_out  output  4  one-cycle completion pulse to the granted requester.
- grant_out  output  2  index of the current or most recent grantee.
- busy_out  output  1  high while in HOLD.
- update_out  output  1  one-cycle pulse in the first cycle a new DAC_out value is visible.
- DAC_out  output  20  signed code to the AD5791 controller DAC input.
- clamp_flag_out  output  1  pulses with update_out when the latched code was saturated.

## Operation
- Reset values, effective at the first edge with rst_in high:
  - DAC_out = 0, ack_out = 0, grant_out = 0, busy_out = 0, update_out = 0, clamp_flag_out = 0.
  - state = IDLE, counter = 0, last pointer = 3, so requester 0 has first priority.
- States: IDLE, HOLD.
- IDLE:
  - Form eff_req = req_in with the bit of any requester whose ack_out is high this cycle masked off. This prevents re-granting a requester in its own ack cycle.
  - If eff_req is nonzero, select the first set bit searching last+1, last+2, … modulo 4.
  - At the next edge, all of the following take effect together: DAC_out ← selected code (saturated if enabled); grant_out ← index; last ← index; update_out ← 1; busy_out ← 1; counter ← UPDATE_PERIOD−1; state ← HOLD.
  - If eff_req is zero, remain in IDLE and hold all outputs except the pulses, which return to 0.
- HOLD:
  - counter decrements each cycle; DAC_out and grant_out are frozen; req_in and data_in are ignored.
  - At the edge where counter == 0: ack_out[grant] ← 1, busy_out ← 0, state ← IDLE.
- Dropping req mid-HOLD does not abort the update; the ack is still issued. Changes to data_in after the grant edge are ignored.
- Simultaneous requests are served strictly round-robin, with no starvation: each requester waits at most 3 full updates.
- Synchronous reset mid-HOLD aborts immediately with no ack, and DAC_out returns to 0.

## Timing
- The grant decision is made in the IDLE cycle, and DAC_out is registered at the following edge E.
- ack_out is high in the cycle starting at edge E+UPDATE_PERIOD.
- Minimum spacing between successive DAC_out updates is UPDATE_PERIOD+1 cycles: the ack cycle is spent in IDLE, and the next grant registers at the following edge.
- Request-to-update latency from IDLE with no contention is 1 cycle.
- ack_out, update_out and clamp_flag_out are always single-cycle pulses, and at most one ack_out bit is high at a time.

## Configuration
- Macro: DAC_ARB_CLAMP_EN.
  - Defined: the code latched at the grant edge is saturated to [CLAMP_MIN, CLAMP_MAX] using signed comparison. clamp_flag_out pulses with update_out whenever saturation changed the value.
  - Undefined: the code passes unmodified, clamp_flag_out is tied to 0, and CLAMP_MIN/CLAMP_MAX are ignored.

## Test plan
- Reset then idle with UPDATE_PERIOD=8: all outputs at reset values and DAC_out=0 for 20 cycles.
- Single request: req_in=4'b0001 with code 20'sh12345 → update_out and DAC_out=20'sh12345 one edge later; ack_out=4'b0001 exactly 8 cycles after that; no re-grant while req is held through the ack cycle.
- Contention: req_in=4'b1111 held continuously → grants in order 0,1,2,3,0 with update_out pulses spaced 9 cycles apart.
- Request drop and reset: req_in[2] dropped at HOLD cycle 3 → ack_out[2] still issued; rst_in asserted at HOLD cycle 5 → no ack, DAC_out=0 next edge.
- Saturation with DAC_ARB_CLAMP_EN, CLAMP_MAX=1000: code 5000 → DAC_out=1000 with clamp_flag_out=1; code −5000 with CLAMP_MIN=−1000 → DAC_out=−1000. With the macro undefined, DAC_out=5000 and clamp_flag_out stays 0.
